// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - control, table-write and output-stream bundle for seq_pattern_gen
interface seq_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              enable;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] last_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  enable, start, mode, last_idx, wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output enable, start, mode, last_idx, wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - writable pattern table played out in loop, one-shot or ping-pong order
module seq_pattern_gen #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    seq_pattern_gen_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]        MODE_ONESHOT  = 2'b01;
    localparam logic [1:0]        MODE_PINGPONG = 2'b10;
    localparam logic [ADDR_W-1:0] LP_MAX_IDX    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LP_ONE        = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_table [DEPTH];
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] w_last_nxt;
    logic [ADDR_W-1:0] w_last_clamped;
    logic [1:0]        r_mode;
    logic [1:0]        w_mode_nxt;
    logic              r_dir_down;
    logic              w_dir_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_run;
    logic              w_fire;
    logic              w_wr_ok;
    logic              w_at_last;
    logic              w_last_beat;

    assign w_run          = (r_state == ST_RUN);
    assign w_fire         = w_run & bus.out_ready & bus.enable;
    assign w_at_last      = (r_idx == r_last);
    assign w_last_clamped = (int'(bus.last_idx) > DEPTH - 1) ? LP_MAX_IDX : bus.last_idx;
    assign w_wr_ok        = bus.wr_en & (int'(bus.wr_addr) < DEPTH);

    // Table: non-blocking write means a same-cycle read still returns the old word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_dir_down <= 1'b0;
            r_mode     <= 2'b00;
            r_last     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_dir_down <= w_dir_nxt;
            r_mode     <= w_mode_nxt;
            r_last     <= w_last_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // start outranks fire; mode and last index are only sampled here
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dir_nxt   = r_dir_down;
        w_mode_nxt  = r_mode;
        w_last_nxt  = r_last;
        w_done_nxt  = r_done;
        if (bus.start) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
            w_dir_nxt   = 1'b0;
            w_mode_nxt  = bus.mode;
            w_last_nxt  = w_last_clamped;
            w_done_nxt  = 1'b0;
        end else if (w_fire) begin
            case (r_mode)
                MODE_ONESHOT: begin
                    if (w_at_last) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + LP_ONE;
                    end
                end
                MODE_PINGPONG: begin
                    if (r_last == '0) begin
                        w_idx_nxt = '0;
                    end else if (!r_dir_down) begin
                        if (w_at_last) begin
                            w_dir_nxt = 1'b1;
                            w_idx_nxt = r_idx - LP_ONE;
                        end else begin
                            w_idx_nxt = r_idx + LP_ONE;
                        end
                    end else begin
                        if (r_idx == '0) begin
                            w_dir_nxt = 1'b0;
                            w_idx_nxt = LP_ONE;
                        end else begin
                            w_idx_nxt = r_idx - LP_ONE;
                        end
                    end
                end
                default: begin
                    w_idx_nxt = w_at_last ? '0 : r_idx + LP_ONE;
                end
            endcase
        end
    end

    // Ping-pong ends a pass on the return to entry 0; a single-entry table ends every beat
    always_comb begin
        w_last_beat = w_at_last;
        if (r_mode == MODE_PINGPONG) begin
            w_last_beat = (r_last == '0) | ((r_idx == '0) & r_dir_down);
        end
    end

    assign bus.out_valid = w_run;
    assign bus.busy      = w_run;
    assign bus.done      = r_done;
    assign bus.out_last  = w_run & w_last_beat;
    assign bus.out_data  = r_table[r_idx];
endmodule
